// File: rtl/boot_pkg.sv
// Shared types and sizing helpers for the boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    LOAD,
    RUN,
    HALTED,
    ERROR
  } boot_state_e;

  localparam int ADDR_W_DEF       = 5;
  localparam int DATA_W_DEF       = 16;
  localparam int RESET_HOLD_DEF   = 4;
  localparam int LOAD_TIMEOUT_DEF = 1024;

  // Wide enough for both the hold preload and the timeout count.
  function automatic int cnt_w(input int tmo, input int hold);
    int w;
    w = $clog2(tmo);
    if ($clog2(hold) > w) w = $clog2(hold);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/boot_sequencer_if.sv
// Loader / memory / CPU signal bundle around the boot sequencer.
// slave = sequencer side, master = surrounding system side.
interface boot_sequencer_if
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
);
  logic                  boot_req;
  logic                  loader_reset;
  logic                  start_load;
  logic                  load_complete;
  logic [ADDR_WIDTH-1:0] ld_mem_addr;
  logic [DATA_WIDTH-1:0] ld_mem_write_data;
  logic                  ld_mem_write;
  logic [ADDR_WIDTH-1:0] cpu_fetch_addr;
  logic                  cpu_reset_n;
  logic                  cpu_halted;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write;
  logic                  boot_done;
  logic                  boot_error;

  modport slave (
    input  boot_req, load_complete,
    input  ld_mem_addr, ld_mem_write_data, ld_mem_write,
    input  cpu_fetch_addr, cpu_halted,
    output loader_reset, start_load, cpu_reset_n,
    output mem_addr, mem_write_data, mem_write,
    output boot_done, boot_error
  );

  modport master (
    output boot_req, load_complete,
    output ld_mem_addr, ld_mem_write_data, ld_mem_write,
    output cpu_fetch_addr, cpu_halted,
    input  loader_reset, start_load, cpu_reset_n,
    input  mem_addr, mem_write_data, mem_write,
    input  boot_done, boot_error
  );
endinterface

// File: rtl/boot_timer.sv
// Loadable up/down counter shared by the HOLD and LOAD phases.
module boot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         up_i,
  input  logic         dn_i,
  input  logic [W-1:0] tc_val_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (up_i) begin
      cnt_q <= cnt_q + 1'b1;
    end else if (dn_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);
endmodule

// File: rtl/boot_sequencer.sv
// Boot FSM and instruction-memory port owner.
// BOOT_AUTOSTART_EN: leave IDLE right after reset without boot_req.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int RESET_HOLD   = RESET_HOLD_DEF,
  parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DEF
) (
  input logic             clock,
  input logic             reset,
  boot_sequencer_if.slave bus
);
  localparam int CW = cnt_w(LOAD_TIMEOUT, RESET_HOLD);

`ifdef BOOT_AUTOSTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif

  boot_state_e state_q, state_d;
  logic          hold_entry, load_entry, tc;
  logic [CW-1:0] load_val, tc_val;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (bus.boot_req || AUTO) state_d = HOLD;
      HOLD:   if (tc) state_d = LOAD;
      LOAD: begin
        if (bus.load_complete) state_d = RUN;
        else if (tc)           state_d = ERROR;
      end
      RUN: begin
        if (bus.boot_req)        state_d = HOLD;
        else if (bus.cpu_halted) state_d = HALTED;
      end
      HALTED: if (bus.boot_req) state_d = HOLD;
      ERROR:  if (bus.boot_req) state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  assign hold_entry = (state_d == HOLD) && (state_q != HOLD);
  assign load_entry = (state_d == LOAD) && (state_q != LOAD);
  assign load_val   = hold_entry ? CW'(RESET_HOLD - 1) : '0;
  assign tc_val     = (state_q == LOAD) ? CW'(LOAD_TIMEOUT - 1) : '0;

  boot_timer #(.W(CW)) u_timer (
    .clk        (clock),
    .rst_n      (reset),
    .load_i     (hold_entry || load_entry),
    .load_val_i (load_val),
    .up_i       (state_q == LOAD),
    .dn_i       (state_q == HOLD),
    .tc_val_i   (tc_val),
    .tc_o       (tc)
  );

  // Control outputs are decoded from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      bus.loader_reset <= 1'b1;
      bus.start_load   <= 1'b0;
      bus.cpu_reset_n  <= 1'b0;
      bus.boot_done    <= 1'b0;
      bus.boot_error   <= 1'b0;
    end else begin
      state_q          <= state_d;
      bus.loader_reset <= state_d inside {IDLE, HOLD, ERROR};
      bus.start_load   <= load_entry;
      bus.cpu_reset_n  <= state_d inside {RUN, HALTED};
      bus.boot_done    <= state_d inside {RUN, HALTED};
      bus.boot_error   <= (state_d == ERROR);
    end
  end

  // The write strobe only ever comes from the loader, and only in LOAD.
  always_comb begin
    bus.mem_addr       = '0;
    bus.mem_write      = 1'b0;
    bus.mem_write_data = bus.ld_mem_write_data;
    unique case (state_q)
      LOAD: begin
        bus.mem_addr  = bus.ld_mem_addr;
        bus.mem_write = bus.ld_mem_write;
      end
      RUN, HALTED: bus.mem_addr = bus.cpu_fetch_addr;
      default: ;
    endcase
  end
endmodule
